// File: rtl/spi_bus_arbiter.sv
// Shares one SPI pin set between NumReq hosts. Whole-transaction round-robin
// grants, a forced-idle guard between owners, registered pin outputs and an
// optional grant timeout.
//
// state | meaning
// IDLE  | no owner, pins idle, arbitrating on req_i
// OWNED | one host granted, its pins registered onto the bus
// GUARD | pins forced idle for GuardCycles clocks after a release
module spi_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int GuardCycles   = 4,
  parameter int MaxHoldCycles = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         gnt_o,
  input  logic [NumReq-1:0]         sclk_i,
  input  logic [NumReq-1:0]         copi_i,
  input  logic [NumReq-1:0]         cs_ni,
  output logic [NumReq-1:0]         cipo_o,
  output logic                      sclk_o,
  output logic                      copi_o,
  output logic                      cs_no,
  input  logic                      cipo_i,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      timeout_o
);

  localparam int OwnW  = $clog2(NumReq);
  localparam int HoldW = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, GUARD} state_t;

  state_t            state_q, state_d;
  logic [OwnW-1:0]   owner_q, owner_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic              sclk_q, sclk_d;
  logic              copi_q, copi_d;
  logic              csn_q, csn_d;
  logic              timeout_q, timeout_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [7:0]        guard_q, guard_d;

  logic [OwnW-1:0]   win;
  logic              found;
  int                idx;
  logic [NumReq-1:0] own_mask;
  logic              own_req, own_csn, own_sclk, own_copi;
  logic              release_ok, hold_expired;

  // Round-robin pick: first requester scanning upward from owner+1 with wrap,
  // so the last owner always ends up with the lowest priority.
  always_comb begin
    win   = owner_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(owner_q) + i) % NumReq;
      if (!found && |(req_i & (NumReq'(1) << idx))) begin
        win   = OwnW'(idx);
        found = 1'b1;
      end
    end
  end

  // Owner's view of the host-side signals, selected through a one-hot mask.
  always_comb begin
    own_mask     = NumReq'(1) << owner_q;
    own_req      = |(req_i & own_mask);
    own_csn      = |(cs_ni & own_mask);
    own_sclk     = |(sclk_i & own_mask);
    own_copi     = |(copi_i & own_mask);
    release_ok   = !own_req && own_csn;
    hold_expired = (MaxHoldCycles > 0) && (hold_q == HoldW'(MaxHoldCycles));
  end

  // Next-state and next-output logic; pins default to idle every cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    sclk_d    = 1'b0;
    copi_d    = 1'b0;
    csn_d     = 1'b1;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    guard_d   = guard_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          owner_d = win;
          gnt_d   = NumReq'(1) << win;
          hold_d  = HoldW'(1);
        end
      end
      OWNED: begin
        if (release_ok || hold_expired) begin
          state_d   = GUARD;
          gnt_d     = '0;
          guard_d   = 8'(GuardCycles - 1);
          timeout_d = !release_ok;
        end else begin
          sclk_d = own_sclk;
          copi_d = own_copi;
          csn_d  = own_csn;
          if (hold_q != {HoldW{1'b1}}) hold_d = hold_q + 1'b1;
        end
      end
      GUARD: begin
        // Arbitration overlaps the last guard cycle, so a waiting host is
        // granted right as the guard ends.
        if (guard_q == 8'd0) begin
          if (found) begin
            state_d = OWNED;
            owner_d = win;
            gnt_d   = NumReq'(1) << win;
            hold_d  = HoldW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= OwnW'(NumReq - 1);
      gnt_q     <= '0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      csn_q     <= 1'b1;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      csn_q     <= csn_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      guard_q   <= guard_d;
    end
  end

  // CIPO is returned combinationally to the owner only.
  always_comb begin
    cipo_o = (state_q == OWNED) ? (own_mask & {NumReq{cipo_i}}) : '0;
  end

  assign gnt_o     = gnt_q;
  assign sclk_o    = sclk_q;
  assign copi_o    = copi_q;
  assign cs_no     = csn_q;
  assign busy_o    = (state_q != IDLE);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a vector table for the basic two-host
// flow, plus sequences for guard gap, request drop, round-robin order,
// timeout and reset mid-transaction.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: two hosts, guard 4, no timeout
  logic [1:0] a_req = '0, a_sclk = '0, a_copi = '0, a_csn = 2'b11;
  logic [1:0] a_gnt, a_cipo_o;
  logic       a_cipo_i = 1'b0, a_sclk_o, a_copi_o, a_csn_o, a_busy, a_tmo;
  logic [0:0] a_owner;

  // DUT B: three hosts
  logic [2:0] b_req = '0, b_sclk = '0, b_copi = '0, b_csn = 3'b111;
  logic [2:0] b_gnt, b_cipo_o;
  logic       b_sclk_o, b_copi_o, b_csn_o, b_busy, b_tmo;
  logic [1:0] b_owner;

  // DUT C: two hosts, timeout 20
  logic [1:0] c_req = '0, c_sclk = '0, c_copi = '0, c_csn = 2'b11;
  logic [1:0] c_gnt, c_cipo_o;
  logic       c_sclk_o, c_copi_o, c_csn_o, c_busy, c_tmo;
  logic [0:0] c_owner;

  spi_bus_arbiter #(.NumReq(2), .GuardCycles(4), .MaxHoldCycles(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt),
    .sclk_i(a_sclk), .copi_i(a_copi), .cs_ni(a_csn), .cipo_o(a_cipo_o),
    .sclk_o(a_sclk_o), .copi_o(a_copi_o), .cs_no(a_csn_o), .cipo_i(a_cipo_i),
    .busy_o(a_busy), .owner_o(a_owner), .timeout_o(a_tmo));

  spi_bus_arbiter #(.NumReq(3), .GuardCycles(4), .MaxHoldCycles(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt),
    .sclk_i(b_sclk), .copi_i(b_copi), .cs_ni(b_csn), .cipo_o(b_cipo_o),
    .sclk_o(b_sclk_o), .copi_o(b_copi_o), .cs_no(b_csn_o), .cipo_i(1'b0),
    .busy_o(b_busy), .owner_o(b_owner), .timeout_o(b_tmo));

  spi_bus_arbiter #(.NumReq(2), .GuardCycles(4), .MaxHoldCycles(20)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .gnt_o(c_gnt),
    .sclk_i(c_sclk), .copi_i(c_copi), .cs_ni(c_csn), .cipo_o(c_cipo_o),
    .sclk_o(c_sclk_o), .copi_o(c_copi_o), .cs_no(c_csn_o), .cipo_i(1'b0),
    .busy_o(c_busy), .owner_o(c_owner), .timeout_o(c_tmo));

  typedef struct {
    logic [1:0] req, sclk, copi, csn;
    logic       cipo;
    logic [1:0] gnt;
    logic       sclk_o, copi_o, csn_o;
    logic [1:0] cipo_o;
    logic       busy;
    logic       own;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dec3(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_low, hi_run, n_g, n_hi, n_tmo, n_zero, hi_at_tmo;
    int order_exp[10];
    logic [2:0] mask, prev;
    logic got;

    //               req    sclk   copi   csn    cipo  gnt   s  c  cs cipo_o busy own
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b11, 1'b1, 2'b01, 0, 0, 1, 2'b01, 1, 0};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 2'b10, 1'b0, 2'b01, 0, 1, 0, 2'b00, 1, 0};
    tbl[2]  = '{2'b01, 2'b11, 2'b11, 2'b10, 1'b1, 2'b01, 1, 1, 0, 2'b01, 1, 0};
    tbl[3]  = '{2'b01, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 0, 0, 0, 2'b00, 1, 0};
    tbl[4]  = '{2'b01, 2'b01, 2'b10, 2'b10, 1'b1, 2'b01, 1, 0, 0, 2'b01, 1, 0};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b01, 0, 0, 0, 2'b00, 1, 0};
    tbl[6]  = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 0, 0, 1, 2'b00, 1, 0};
    tbl[7]  = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 0, 0, 1, 2'b00, 1, 0};
    tbl[8]  = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 0, 0, 1, 2'b00, 1, 0};
    tbl[9]  = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 0, 0, 1, 2'b00, 1, 0};
    tbl[10] = '{2'b10, 2'b00, 2'b00, 2'b11, 1'b1, 2'b10, 0, 0, 1, 2'b10, 1, 1};
    tbl[11] = '{2'b10, 2'b10, 2'b10, 2'b01, 1'b0, 2'b10, 1, 1, 0, 2'b00, 1, 1};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 0, 0, 1, 2'b00, 1, 1};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 0, 0, 1, 2'b00, 1, 1};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 0, 0, 1, 2'b00, 1, 1};
    tbl[15] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 0, 0, 1, 2'b00, 1, 1};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 0, 0, 1, 2'b00, 0, 1};
    tbl[17] = '{2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 0, 0, 1, 2'b00, 1, 0};
    order_exp = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_gnt", a_gnt, 2'b00);
    chk("rst_csn", a_csn_o, 1'b1);
    chk("rst_sclk", a_sclk_o, 1'b0);
    chk("rst_copi", a_copi_o, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_tmo", a_tmo, 1'b0);
    chk("rst_owner", a_owner, 1'b1);
    chk("rst_owner_b", b_owner, 2'd2);
    rst = 1'b0;

    // Basic flow: grant, pin mirroring, request drop, release, guard, handover
    for (int v = 0; v < 18; v++) begin
      a_req = tbl[v].req; a_sclk = tbl[v].sclk; a_copi = tbl[v].copi;
      a_csn = tbl[v].csn; a_cipo_i = tbl[v].cipo;
      tick();
      chk($sformatf("v%0d_gnt", v), a_gnt, tbl[v].gnt);
      chk($sformatf("v%0d_sclk", v), a_sclk_o, tbl[v].sclk_o);
      chk($sformatf("v%0d_copi", v), a_copi_o, tbl[v].copi_o);
      chk($sformatf("v%0d_csn", v), a_csn_o, tbl[v].csn_o);
      chk($sformatf("v%0d_cipo", v), a_cipo_o, tbl[v].cipo_o);
      chk($sformatf("v%0d_busy", v), a_busy, tbl[v].busy);
      chk($sformatf("v%0d_owner", v), a_owner, tbl[v].own);
    end

    // Host 0 owns (both requesting), runs 16 SCLK edges, then hands over
    a_req = 2'b11; a_csn = 2'b10; a_cipo_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_sclk = {1'b0, ~a_sclk[0]};
      tick();
      chk("xfer_gnt", a_gnt, 2'b01);
    end
    a_req = 2'b10; a_csn = 2'b11; a_sclk = 2'b00;
    n_low = 0; hi_run = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (a_csn_o) hi_run++; else hi_run = 0;
      if (a_gnt == 2'b00) n_low++;
      if (a_gnt == 2'b10) got = 1'b1;
    end
    chk("handover_seen", got, 1'b1);
    chk("handover_gnt_low", n_low, 4);
    a_csn = 2'b01;
    tick();
    chk("handover_csn_low", a_csn_o, 1'b0);
    chk("handover_gap_ge5", (hi_run >= 5), 1'b1);
    a_req = 2'b00; a_csn = 2'b11;

    // Request dropped mid-transaction: grant held until cs_n rises
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (!a_busy) got = 1'b1;
    end
    chk("idle_seen", got, 1'b1);
    a_req = 2'b01;
    tick();
    chk("drop_grant", a_gnt, 2'b01);
    a_csn = 2'b10;
    tick();
    a_req = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("drop_hold_gnt", a_gnt, 2'b01);
      chk("drop_hold_csn", a_csn_o, 1'b0);
    end
    a_csn = 2'b11;
    tick();
    chk("drop_release_gnt", a_gnt, 2'b00);
    chk("drop_release_csn", a_csn_o, 1'b1);

    // Three hosts: full round-robin, then with host 1 absent
    mask = 3'b111; prev = 3'b000; n_g = 0;
    b_req = mask;
    for (int k = 0; k < 300 && n_g < 10; k++) begin
      tick();
      if (b_gnt != 3'b000 && prev == 3'b000) begin
        chk($sformatf("rr_order%0d", n_g), dec3(b_gnt), order_exp[n_g]);
        n_g++;
        if (n_g == 6) mask = 3'b101;
      end
      prev = b_gnt;
      b_req = mask & ~b_gnt;
    end
    chk("rr_count", n_g, 10);
    b_req = 3'b000;

    // Timeout: host 0 keeps cs_n low forever, host 1 waits
    c_req = 2'b01;
    tick();
    chk("tmo_grant", c_gnt, 2'b01);
    c_req = 2'b11; c_csn = 2'b10;
    n_hi = 1; n_tmo = 0; n_zero = 0; hi_at_tmo = -1; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (c_gnt == 2'b01) n_hi++;
      if (c_tmo) begin
        n_tmo++;
        hi_at_tmo = n_hi;
        chk("tmo_gnt_dropped", c_gnt, 2'b00);
        chk("tmo_csn_high", c_csn_o, 1'b1);
      end
      if (c_gnt == 2'b00) n_zero++;
      if (c_gnt == 2'b10) got = 1'b1;
    end
    chk("tmo_next_grant", got, 1'b1);
    chk("tmo_hold_len", n_hi, 20);
    chk("tmo_pulse_count", n_tmo, 1);
    chk("tmo_pulse_pos", hi_at_tmo, 20);
    chk("tmo_guard_len", n_zero, 4);
    c_req = 2'b00; c_csn = 2'b11;

    // Reset while host 0 owns the bus with cs_n low
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (!a_busy) got = 1'b1;
    end
    chk("idle_seen2", got, 1'b1);
    a_req = 2'b01;
    tick();
    chk("mr_grant", a_gnt, 2'b01);
    a_csn = 2'b10; a_sclk = 2'b01;
    tick();
    chk("mr_csn_low", a_csn_o, 1'b0);
    chk("mr_sclk_high", a_sclk_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("mr_gnt", a_gnt, 2'b00);
    chk("mr_csn", a_csn_o, 1'b1);
    chk("mr_sclk", a_sclk_o, 1'b0);
    chk("mr_busy", a_busy, 1'b0);
    chk("mr_owner", a_owner, 1'b1);
    rst = 1'b0;
    tick();
    chk("mr_regrant", a_gnt, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
